flash_line_arb: RTL and testbench
=================================

// Module: flash_line_arb
// PURPOSE
//  Two-port arbiter/sequencer sharing one QSPI line-fetch engine (flash_ctrl_eb) between two
//  line-fill requesters, e.g. instruction-cache and data-cache miss ports. Grants round-robin,
//  issues one fetch at a time, returns the fetched line and a done pulse to the owner.
// PARAMETERS
//  LW        256  line width in bits (must match the fetch engine's LW)
//  TO_CYCLES 1023 watchdog limit in cycles for f_done (used only with FLASH_ARB_TIMEOUT_EN)
// PORTS
//  HCLK     in  1   clock
//  HRESET   in  1   synchronous reset, active high
//  r0_req   in  1   port-0 fetch request, level; held until r0_done
//  r0_addr  in  24  port-0 line address; stable while r0_req=1
//  r0_done  out 1   port-0 completion pulse (1 cycle); rd_data valid this cycle
//  r1_req   in  1   port-1 fetch request (as r0_req)
//  r1_addr  in  24  port-1 line address
//  r1_done  out 1   port-1 completion pulse
//  rd_data  out LW  registered fetched line; held until the next completion
//  f_start  out 1   fetch-engine start pulse (1 cycle)
//  f_addr   out 24  fetch address; registered, stable from f_start until f_done
//  f_done   in  1   fetch-engine done pulse
//  f_data   in  LW  fetch-engine line data; sampled when f_done=1
//  busy     out 1   1 in every state except IDLE
//  owner    out 1   port owning the current/last transaction
//  err      out 1   timeout pulse (1 cycle, with rX_done); constant 0 without the macro
// BEHAVIOUR
//  Reset: state=IDLE, rr=0. Outputs f_start, f_addr, r0_done, r1_done, rd_data, busy, owner, err = 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : if r0_req|r1_req, pick a winner, f_addr<=winner addr, owner<=winner, go to ISSUE.
//          Otherwise stay in IDLE.
//   ISSUE: f_start=1 (decoded from state, exactly one cycle), go to WAIT.
//   WAIT : on f_done, rd_data<=f_data, go to RESP. Otherwise stay in WAIT.
//   RESP : r<owner>_done=1 for one cycle, rr<=~owner, go to IDLE.
//  Arbitration: if only one port requests, it wins. If both request, port rr wins.
//   rr updates only in RESP, so back-to-back requesters alternate strictly.
//  Latency: req sampled high in IDLE at cycle T -> f_start at T+1.
//   f_done at cycle W -> done at W+1.
//   Unloaded minimum from req to done is 3 cycles plus the engine time.
//  Requester contract: deassert req on the clock edge at which rX_done=1 is sampled.
//   A re-assert may follow one cycle later and is arbitrated normally.
//  Boundaries:
//   - f_done outside WAIT is ignored.
//   - req dropped mid-transaction: the fetch still completes and done still pulses (requester ignores it).
//   - r0_addr/r1_addr changes after the grant have no effect (f_addr already latched).
//   - Both requests rising in the same cycle from reset: port 0 wins (rr=0).
//   - HRESET mid-transaction: FSM to IDLE, all outputs to reset values, no done pulse.
//     The fetch engine must share this reset.
//   - Only one transaction is outstanding at a time; there is no queueing beyond the held req levels.
// CONFIGURATION
//  FLASH_ARB_TIMEOUT_EN defined:
//   - An 10-bit cycle counter clears on ISSUE and counts in WAIT.
//   - When it reaches TO_CYCLES without f_done: rd_data<={LW{1'b1}}, go to RESP,
//     and err=1 together with rX_done. f_done is then ignored until the next WAIT.
//  FLASH_ARB_TIMEOUT_EN undefined:
//   - No counter; WAIT waits indefinitely; err tied 0.
// TESTING
//  1. Single port 0: r0_req=1, r0_addr=24'h000100, engine done after 40 cycles with
//     f_data=pattern A -> f_start 1 cycle after req, f_addr=24'h000100,
//     r0_done 1 cycle after f_done, rd_data=A, r1_done never asserts.
//  2. Simultaneous r0_req=r1_req=1 after reset (addr 24'h10/24'h20) -> port 0 served first;
//     port 1 f_start 2 cycles after r0_done with f_addr=24'h20; owner=1.
//  3. Both held continuously for 6 transactions -> grant order 0,1,0,1,0,1.
//     Exactly one f_start per done; f_addr never changes while busy.
//  4. HRESET pulsed 5 cycles into WAIT -> no rX_done, busy=0 next cycle, rr=0.
//     A following r1_req completes normally.
//  5. Stray f_done in IDLE and a spurious second f_done in RESP -> no extra done pulse,
//     rd_data unchanged.
//  6. With FLASH_ARB_TIMEOUT_EN, TO_CYCLES=16, engine never finishes -> r0_done and err
//     high together, 17 cycles after f_start, with rd_data all ones.
//     Without the macro: busy stays 1 and err=0.

Source files
------------

// File: rtl/flash_line_arb.sv
// Round-robin arbiter/sequencer sharing one QSPI line-fetch engine between two line-fill ports.
// Optional f_done watchdog is compiled in by defining FLASH_ARB_TIMEOUT_EN.
module flash_line_arb #(
  parameter int unsigned LW        = 256,
  parameter int unsigned TO_CYCLES = 1023
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          r0_req,
  input  logic [23:0]   r0_addr,
  output logic          r0_done,
  input  logic          r1_req,
  input  logic [23:0]   r1_addr,
  output logic          r1_done,
  output logic [LW-1:0] rd_data,
  output logic          f_start,
  output logic [23:0]   f_addr,
  input  logic          f_done,
  input  logic [LW-1:0] f_data,
  output logic          busy,
  output logic          owner,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          grant_c;
  logic          timeout_c;
  logic          owner_d, f_start_d, r0_done_d, r1_done_d, busy_d, err_d;
  logic [23:0]   f_addr_d;
  logic [LW-1:0] rd_data_d;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int unsigned CW = 10;

  logic [CW-1:0] wd_cnt_q;

  // Watchdog: cleared while issuing, counts every cycle spent waiting for f_done.
  always_ff @(posedge HCLK) begin
    if (HRESET || state_q == S_ISSUE) wd_cnt_q <= '0;
    else if (state_q == S_WAIT)       wd_cnt_q <= wd_cnt_q + CW'(1);
  end

  assign timeout_c = (wd_cnt_q == CW'(TO_CYCLES - 1));
`else
  // Watchdog compiled out: WAIT holds until f_done and TO_CYCLES has no effect.
  assign timeout_c = 1'b0 & (TO_CYCLES != 0);
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner   <= 1'b0;
      f_addr  <= '0;
      rd_data <= '0;
      f_start <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner   <= owner_d;
      f_addr  <= f_addr_d;
      rd_data <= rd_data_d;
      f_start <= f_start_d;
      r0_done <= r0_done_d;
      r1_done <= r1_done_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

  // Lone requester wins; on contention the round-robin pointer picks the port.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner;
    f_addr_d  = f_addr;
    rd_data_d = rd_data;
    f_start_d = 1'b0;
    r0_done_d = 1'b0;
    r1_done_d = 1'b0;
    err_d     = 1'b0;
    grant_c   = r1_req & (~r0_req | rr_q);

    unique case (state_q)
      S_IDLE: begin
        if (r0_req | r1_req) begin
          state_d   = S_ISSUE;
          owner_d   = grant_c;
          f_addr_d  = grant_c ? r1_addr : r0_addr;
          f_start_d = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (f_done || timeout_c) begin
          state_d   = S_RESP;
          rd_data_d = f_done ? f_data : '1;
          err_d     = ~f_done;
          r0_done_d = ~owner;
          r1_done_d = owner;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rr_d    = ~owner;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_flash_line_arb.sv
// Directed bench for flash_line_arb: transaction-timing model plus hand-computed expectations.
module tb_flash_line_arb;

  localparam int unsigned LW = 256;
  localparam int TO_CYCLES = 16;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          r0_req = 1'b0, r1_req = 1'b0;
  logic [23:0]   r0_addr = '0, r1_addr = '0;
  logic          r0_done, r1_done, f_start, busy, owner, err;
  logic [LW-1:0] rd_data;
  logic [23:0]   f_addr;
  logic          f_done = 1'b0;
  logic [LW-1:0] f_data = '0;

  flash_line_arb #(.LW(LW), .TO_CYCLES(TO_CYCLES)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_done(r0_done),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_done(r1_done),
    .rd_data(rd_data), .f_start(f_start), .f_addr(f_addr),
    .f_done(f_done), .f_data(f_data),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pat(input logic [23:0] a);
    return {8{8'hC3, a}};
  endfunction

  // Transaction-timing model: a transaction has an age (0 = start cycle); the engine may
  // finish from age 1 on; the response cycle follows, then one free cycle before a new grant.
  bit          in_txn = 0, resp = 0;
  int          age = 0;
  logic        m_rr = 0, m_owner = 0, m_start = 0, m_d0 = 0, m_d1 = 0, m_err = 0;
  logic [23:0] m_faddr = '0;
  logic [LW-1:0] m_rd = '0;

  always @(posedge HCLK) begin
    m_start = 0; m_d0 = 0; m_d1 = 0; m_err = 0;
    if (HRESET) begin
      in_txn = 0; resp = 0; age = 0; m_rr = 0; m_owner = 0; m_faddr = '0; m_rd = '0;
    end else if (!in_txn) begin
      if (r0_req || r1_req) begin
        m_owner = (r0_req && r1_req) ? m_rr : r1_req;
        m_faddr = m_owner ? r1_addr : r0_addr;
        in_txn = 1; resp = 0; age = 0; m_start = 1;
      end
    end else if (resp) begin
      in_txn = 0; resp = 0; m_rr = !m_owner;
    end else begin
      if (age >= 1 && f_done) begin
        resp = 1; m_rd = f_data;
      end
`ifdef FLASH_ARB_TIMEOUT_EN
      else if (age == TO_CYCLES) begin
        resp = 1; m_rd = '1; m_err = 1;
      end
`endif
      if (resp) begin m_d0 = !m_owner; m_d1 = m_owner; end
      age++;
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      chk("f_start", f_start, m_start);
      chk("f_addr", f_addr, m_faddr);
      chk("r0_done", r0_done, m_d0);
      chk("r1_done", r1_done, m_d1);
      chk("rd_data", rd_data, m_rd);
      chk("busy", busy, in_txn);
      chk("owner", owner, m_owner);
      chk("err", err, m_err);
    end
  end

  // Engine emulation and requester reactions, one call per cycle.
  int eng_lat = 0, eng_cnt = 0;
  int n_start = 0, n_d0 = 0, n_d1 = 0;
  int t_start = 0, t_fd = 0, t_d0 = 0;
  bit hold = 0;

  task automatic step();
    @(negedge HCLK);
    f_done = 1'b0;
    if (HRESET) eng_cnt = 0;
    else if (f_start) eng_cnt = eng_lat;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin f_done = 1'b1; f_data = pat(f_addr); t_fd = cyc; end
    end
    if (f_start) begin n_start++; t_start = cyc; end
    if (r0_done) begin n_d0++; t_d0 = cyc; if (!hold) r0_req = 1'b0; end
    if (r1_done) begin n_d1++; if (!hold) r1_req = 1'b0; end
  endtask

  task automatic wait_sig(input int sel, input int maxc, input string nm, output int t);
    bit hit;
    hit = 0;
    t = -1;
    for (int i = 0; i < maxc && !hit; i++) begin
      step();
      hit = (sel == 0) ? f_start : (sel == 1) ? r0_done : r1_done;
    end
    if (hit) t = cyc;
    else begin
      checks++; errors++;
      $display("FAIL %s: event absent after %0d cycles, required within that bound", nm, maxc);
    end
  endtask

  int ts, td, td2, nb0, nb1;
  int order [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_busy", busy, 0); chk("rst_owner", owner, 0); chk("rst_f_start", f_start, 0);
    chk("rst_f_addr", f_addr, 0); chk("rst_rd_data", rd_data, 0); chk("rst_err", err, 0);
    chk("rst_r0_done", r0_done, 0); chk("rst_r1_done", r1_done, 0);
    HRESET = 1'b0;
    cmp_en = 1'b1;
    step();

    // 1: single port 0, engine takes 40 cycles
    eng_lat = 40; nb1 = n_d1;
    r0_addr = 24'h000100; r0_req = 1'b1; td2 = cyc;
    wait_sig(0, 10, "t1_start", ts);
    chk("t1_start_lat", ts - td2, 1);
    chk("t1_f_addr", f_addr, 24'h000100);
    wait_sig(1, 80, "t1_done", td);
    chk("t1_done_lat", td - t_fd, 1);
    chk("t1_start_to_done", td - ts, 41);
    chk("t1_rd_data", rd_data, {8{32'hC3000100}});
    repeat (3) step();
    chk("t1_no_r1_done", n_d1 - nb1, 0);

    // 2: simultaneous requests after reset, port 0 first
    HRESET = 1'b1; step(); step(); HRESET = 1'b0;
    eng_lat = 5;
    r0_addr = 24'h000010; r1_addr = 24'h000020; r0_req = 1'b1; r1_req = 1'b1;
    wait_sig(0, 10, "t2_start0", ts);
    chk("t2_owner0", owner, 0);
    chk("t2_f_addr0", f_addr, 24'h000010);
    wait_sig(1, 20, "t2_done0", td);
    wait_sig(0, 10, "t2_start1", ts);
    chk("t2_gap", ts - td, 2);
    chk("t2_f_addr1", f_addr, 24'h000020);
    chk("t2_owner1", owner, 1);
    wait_sig(2, 20, "t2_done1", td);
    step();

    // 3: both held for six transactions
    hold = 1; nb0 = n_start; nb1 = n_d0 + n_d1;
    r0_addr = 24'h000030; r1_addr = 24'h000040; r0_req = 1'b1; r1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_sig(0, 10, "t3_start", ts);
      chk("t3_owner", owner, order[i]);
      chk("t3_f_addr", f_addr, order[i] ? 24'h000040 : 24'h000030);
      wait_sig(order[i] ? 2 : 1, 20, "t3_done", td);
    end
    r0_req = 1'b0; r1_req = 1'b0; hold = 0;
    repeat (3) step();
    chk("t3_n_start", n_start - nb0, 6);
    chk("t3_n_done", n_d0 + n_d1 - nb1, 6);

    // 4: reset 5 cycles into WAIT, then port 1 alone
    eng_lat = 0; nb0 = n_d0 + n_d1;
    r0_addr = 24'h000050; r0_req = 1'b1;
    wait_sig(0, 10, "t4_start", ts);
    repeat (5) step();
    HRESET = 1'b1; r0_req = 1'b0;
    step();
    chk("t4_busy_after_rst", busy, 0);
    HRESET = 1'b0;
    step();
    chk("t4_no_done", n_d0 + n_d1 - nb0, 0);
    eng_lat = 3;
    r1_addr = 24'h000060; r1_req = 1'b1;
    wait_sig(0, 10, "t4_start1", ts);
    chk("t4_owner1", owner, 1);
    chk("t4_f_addr1", f_addr, 24'h000060);
    wait_sig(2, 20, "t4_done1", td);
    chk("t4_rd_data", rd_data, {8{32'hC3000060}});
    step();

    // 5: stray f_done in IDLE, spurious second f_done in RESP
    step();
    f_done = 1'b1; f_data = {8{32'hDEADBEEF}};
    step(); step();
    chk("t5_rd_unchanged", rd_data, {8{32'hC3000060}});
    eng_lat = 4; nb0 = n_d0;
    r0_addr = 24'h000070; r0_req = 1'b1;
    wait_sig(1, 20, "t5_done", td);
    f_done = 1'b1; f_data = {8{32'h5A5A5A5A}};
    repeat (4) step();
    chk("t5_one_done", n_d0 - nb0, 1);
    chk("t5_rd_data", rd_data, {8{32'hC3000070}});

    // 6: engine never finishes
    eng_lat = 0;
    r0_addr = 24'h000080; r0_req = 1'b1;
    wait_sig(0, 10, "t6_start", ts);
`ifdef FLASH_ARB_TIMEOUT_EN
    wait_sig(1, 40, "t6_done", td);
    chk("t6_lat", td - ts, 17);
    chk("t6_err", err, 1);
    chk("t6_rd_ones", rd_data, {LW{1'b1}});
    repeat (3) step();
`else
    repeat (40) step();
    chk("t6_busy_held", busy, 1);
    chk("t6_err_zero", err, 0);
    HRESET = 1'b1; r0_req = 1'b0; step(); HRESET = 1'b0; step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
